layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_pkg.sv | 20 ++
 rtl/layer_sequencer_if.sv | 27 ++
 rtl/layer_sequencer_drain_timer.sv | 33 +++
 rtl/layer_sequencer.sv | 129 ++++++++++++
 tb/tb_layer_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the two-layer inference sequencer.
package nn_pkg;

  localparam int N_IN   = 784;
  localparam int N_HID  = 32;
  localparam int N_OUT  = 10;
  localparam int DRAIN1 = 2;
  localparam int DRAIN2 = 2;
  localparam int CNT_W  = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_RUN   = 3'd1,
    L1_DRAIN = 3'd2,
    L2_RUN   = 3'd3,
    L2_DRAIN = 3'd4,
    DONE     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control and image-stream bundle between the sequencer and its host / systolic arrays.
interface layer_sequencer_if;

  logic        go;
  logic        abort;
  logic        img_valid;
  logic        img_ready;
  logic        start1;
  logic        stop1;
  logic        start2;
  logic        stop2;
  logic [31:0] counter1;
  logic [31:0] counter2;
  logic        busy;
  logic        done;

  modport slave (
    input  go, abort, img_valid,
    output img_ready, start1, stop1, start2, stop2, counter1, counter2, busy, done
  );

  modport master (
    output go, abort, img_valid,
    input  img_ready, start1, stop1, start2, stop2, counter1, counter2, busy, done
  );

endinterface

// File: rtl/layer_sequencer_drain_timer.sv
// Loadable down-counter with a zero flag; shared by both systolic flush phases.
module drain_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: clear beats load, load beats decrement, never underflows
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one inference: pixel stream into layer 1, flush, hidden sweep into layer 2, flush, done.
module layer_sequencer #(
  parameter int N_IN   = nn_pkg::N_IN,
  parameter int N_HID  = nn_pkg::N_HID,
  parameter int DRAIN1 = nn_pkg::DRAIN1,
  parameter int DRAIN2 = nn_pkg::DRAIN2
) (
  input  logic             clk,
  input  logic             reset,
  layer_sequencer_if.slave bus
);

  import nn_pkg::*;

  if ((DRAIN1 < 1) || (DRAIN2 < 1)) begin : g_bad_drain
    $error("layer_sequencer: DRAIN1 and DRAIN2 must both be at least 1");
  end

  seq_state_t  state_r, state_nxt_s;
  logic [31:0] c1_r, c1_nxt_s;
  logic [31:0] c2_r, c2_nxt_s;
  logic        stop1_r, stop2_r;
  logic        t_load_s, t_dec_s, t_zero_s;
  logic [31:0] t_val_s;
  logic        accept_s;

  assign accept_s = (state_r == L1_RUN) && bus.img_valid;

  // Next-state, counter and drain-timer control; abort overrides everything
  always_comb begin
    state_nxt_s = state_r;
    c1_nxt_s    = c1_r;
    c2_nxt_s    = c2_r;
    t_load_s    = 1'b0;
    t_val_s     = 32'd0;
    t_dec_s     = 1'b0;
    if (bus.abort) begin
      state_nxt_s = IDLE;
      c1_nxt_s    = 32'd0;
      c2_nxt_s    = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.go) begin
            state_nxt_s = L1_RUN;
            c1_nxt_s    = 32'd0;
            c2_nxt_s    = 32'd0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        L1_RUN: begin
          if (accept_s && (c1_r == 32'(N_IN - 1))) begin
            state_nxt_s = L1_DRAIN;
            t_load_s    = 1'b1;
            t_val_s     = 32'(DRAIN1 - 1);
          end else if (accept_s) begin
            c1_nxt_s = c1_r + 32'd1;
          end else begin
            c1_nxt_s = c1_r;
          end
        end
        L1_DRAIN: begin
          if (t_zero_s) begin
            state_nxt_s = L2_RUN;
          end else begin
            t_dec_s = 1'b1;
          end
        end
        L2_RUN: begin
          if (c2_r == 32'(N_HID - 1)) begin
            state_nxt_s = L2_DRAIN;
            t_load_s    = 1'b1;
            t_val_s     = 32'(DRAIN2 - 1);
          end else begin
            c2_nxt_s = c2_r + 32'd1;
          end
        end
        L2_DRAIN: begin
          if (t_zero_s) begin
            state_nxt_s = DONE;
          end else begin
            t_dec_s = 1'b1;
          end
        end
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, counters and first-drain-cycle pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      c1_r    <= 32'd0;
      c2_r    <= 32'd0;
      stop1_r <= 1'b0;
      stop2_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      c1_r    <= c1_nxt_s;
      c2_r    <= c2_nxt_s;
      stop1_r <= (state_nxt_s == L1_DRAIN) && (state_r != L1_DRAIN);
      stop2_r <= (state_nxt_s == L2_DRAIN) && (state_r != L2_DRAIN);
    end
  end

  drain_timer #(.W(32)) u_drain (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.abort),
    .load     (t_load_s),
    .load_val (t_val_s),
    .dec      (t_dec_s),
    .zero     (t_zero_s)
  );

  assign bus.img_ready = (state_r == L1_RUN);
  assign bus.start1    = accept_s;
  assign bus.stop1     = stop1_r;
  assign bus.start2    = (state_r == L2_RUN);
  assign bus.stop2     = stop2_r;
  assign bus.counter1  = c1_r;
  assign bus.counter2  = c2_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = (state_r == DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench: elapsed-count reference model, timing table and directed corner sequences.
module tb_layer_sequencer;

  localparam int NI  = 784;
  localparam int NH  = 32;
  localparam int D1  = 2;
  localparam int D2  = 2;
  localparam int TOT = D1 + NH + D2 + 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  layer_sequencer_if bus();

  layer_sequencer #(.N_IN(NI), .N_HID(NH), .DRAIN1(D1), .DRAIN2(D2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        img_ready;
    logic        start1;
    logic        stop1;
    logic        start2;
    logic        stop2;
    logic        busy;
    logic        done;
    logic [31:0] counter1;
    logic [31:0] counter2;
  } outs_t;

  typedef struct {
    int   cyc;
    logic go;
    logic valid;
    logic busy;
    logic rdy;
    logic stop1;
    logic start2;
    logic stop2;
    logic done;
    int   c1;
    int   c2;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int stop1_n, stop2_n, done_n, done_cyc, stop1_cyc, stop2_cyc;

  // Reference: inference progress as pixels accepted (p) and cycles since the last pixel (k)
  bit m_run;
  int m_p, m_k, m_c1, m_c2;

  function automatic outs_t dut_outs();
    return outs_t'({bus.img_ready, bus.start1, bus.stop1, bus.start2, bus.stop2,
                    bus.busy, bus.done, bus.counter1, bus.counter2});
  endfunction

  function automatic outs_t expect_outs();
    outs_t e;
    e = '0;
    e.counter1 = 32'(m_c1);
    e.counter2 = 32'(m_c2);
    if (m_run) begin
      e.busy = 1'b1;
      if (m_p < NI) begin
        e.img_ready = 1'b1;
        e.start1    = bus.img_valid;
        e.counter1  = 32'(m_p);
        e.counter2  = 32'd0;
      end else begin
        e.counter1 = 32'(NI - 1);
        if (m_k <= D1) begin
          e.stop1    = (m_k == 1);
          e.counter2 = 32'd0;
        end else if (m_k <= D1 + NH) begin
          e.start2   = 1'b1;
          e.counter2 = 32'(m_k - D1 - 1);
        end else if (m_k <= D1 + NH + D2) begin
          e.stop2    = (m_k == D1 + NH + 1);
          e.counter2 = 32'(NH - 1);
        end else begin
          e.done     = 1'b1;
          e.counter2 = 32'(NH - 1);
        end
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    if (bus.abort) begin
      m_run = 1'b0; m_c1 = 0; m_c2 = 0;
    end else if (!m_run) begin
      if (bus.go) begin m_run = 1'b1; m_p = 0; m_k = 0; end
    end else if (m_p < NI) begin
      if (bus.img_valid) begin
        m_p++;
        if (m_p == NI) m_k = 1;
      end
    end else begin
      m_k++;
      if (m_k > TOT) begin m_run = 1'b0; m_c1 = NI - 1; m_c2 = NH - 1; end
    end
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  task automatic chk_outs(input string name, input outs_t got, input outs_t want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got rdy%b s1%b p1%b s2%b p2%b busy%b done%b c1=%0d c2=%0d want rdy%b s1%b p1%b s2%b p2%b busy%b done%b c1=%0d c2=%0d",
               name, cyc, got.img_ready, got.start1, got.stop1, got.start2, got.stop2, got.busy,
               got.done, got.counter1, got.counter2, want.img_ready, want.start1, want.stop1,
               want.start2, want.stop2, want.busy, want.done, want.counter1, want.counter2);
    end
  endtask

  task automatic clear_tallies();
    stop1_n = 0; stop2_n = 0; done_n = 0;
    done_cyc = -1; stop1_cyc = -1; stop2_cyc = -1;
  endtask

  // One clock: model advances on the edge, inputs change after it, outputs sampled 2 ns later
  task automatic tick(input logic g, input logic a, input logic v);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    bus.go = g; bus.abort = a; bus.img_valid = v;
    #1;
    chk_outs("model", dut_outs(), expect_outs());
    if (bus.stop1) begin stop1_n++; stop1_cyc = cyc; end
    if (bus.stop2) begin stop2_n++; stop2_cyc = cyc; end
    if (bus.done)  begin done_n++;  done_cyc  = cyc; end
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_run = 1'b0; m_c1 = 0; m_c2 = 0;
    cyc = 0;
    clear_tallies();
  endtask

  task automatic reset_dut();
    bus.go = 1'b0; bus.abort = 1'b0; bus.img_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outs("reset_outs", dut_outs(), '0);
    release_reset();
  endtask

  vec_t tbl[13];

  initial begin
    bus.go = 1'b0; bus.abort = 1'b0; bus.img_valid = 1'b0;
    clear_tallies();

    // Nominal run, go in cycle 10, img_valid held high
    tbl[0]  = '{5,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,   0};
    tbl[1]  = '{10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,   0};
    tbl[2]  = '{11,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,   0};
    tbl[3]  = '{12,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,   0};
    tbl[4]  = '{794, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 783, 0};
    tbl[5]  = '{795, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 783, 0};
    tbl[6]  = '{796, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 783, 0};
    tbl[7]  = '{797, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 783, 0};
    tbl[8]  = '{828, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 783, 31};
    tbl[9]  = '{829, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 783, 31};
    tbl[10] = '{830, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 783, 31};
    tbl[11] = '{831, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 783, 31};
    tbl[12] = '{832, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 783, 31};

    reset_dut();
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].cyc) begin
        if (cyc + 1 == tbl[i].cyc) tick(tbl[i].go, 1'b0, tbl[i].valid);
        else                       tick(1'b0, 1'b0, 1'b1);
      end
      chk("tbl_busy",   bus.busy,      tbl[i].busy);
      chk("tbl_ready",  bus.img_ready, tbl[i].rdy);
      chk("tbl_stop1",  bus.stop1,     tbl[i].stop1);
      chk("tbl_start2", bus.start2,    tbl[i].start2);
      chk("tbl_stop2",  bus.stop2,     tbl[i].stop2);
      chk("tbl_done",   bus.done,      tbl[i].done);
      chk("tbl_c1",     bus.counter1,  tbl[i].c1);
      chk("tbl_c2",     bus.counter2,  tbl[i].c2);
    end
    chk("nominal_stop1_n", stop1_n, 1);
    chk("nominal_stop2_n", stop2_n, 1);
    chk("nominal_done_n",  done_n,  1);

    // Five-cycle stall at pixel 100 delays done by exactly five cycles
    reset_dut();
    for (int c = 1; c <= 900; c++) begin
      tick(c == 10, 1'b0, !(c >= 111 && c <= 115));
      if (c >= 111 && c <= 115) begin
        chk("stall_c1",     bus.counter1, 100);
        chk("stall_start1", bus.start1,   0);
      end
    end
    chk("stall_done_cyc", done_cyc, 836);
    chk("stall_done_n",   done_n,   1);

    // Abort at pixel 400, then a clean inference
    reset_dut();
    for (int c = 1; c <= 420; c++) begin
      tick(c == 10, c == 411, 1'b1);
      if (c == 412) begin
        chk("abort_busy", bus.busy,     0);
        chk("abort_c1",   bus.counter1, 0);
      end
    end
    chk("abort_stop1_n", stop1_n, 0);
    chk("abort_done_n",  done_n,  0);
    for (int c = 421; c <= 1260; c++) tick(c == 425, 1'b0, 1'b1);
    chk("after_abort_done_cyc", done_cyc, 1246);
    chk("after_abort_done_n",   done_n,   1);

    // go re-pulsed during layer-2 sweep is ignored
    reset_dut();
    for (int c = 1; c <= 900; c++) tick(c == 10 || c == 800 || c == 820, 1'b0, 1'b1);
    chk("rego_done_n",   done_n,   1);
    chk("rego_done_cyc", done_cyc, 831);

    // Reset during layer-1 drain: outputs drop immediately, no done afterwards
    reset_dut();
    for (int c = 1; c <= 795; c++) tick(c == 10, 1'b0, 1'b1);
    chk("drain_stop1", bus.stop1, 1);
    #1;
    reset = 1'b0;
    #1;
    chk_outs("async_reset", dut_outs(), '0);
    release_reset();
    for (int c = 1; c <= 60; c++) tick(1'b0, 1'b0, 1'b1);
    chk("post_reset_done_n", done_n, 0);
    chk("post_reset_busy",   bus.busy, 0);

    // go sampled in the very first cycle after reset release
    reset_dut();
    bus.go = 1'b1; bus.img_valid = 1'b1;
    for (int c = 1; c <= 830; c++) tick(1'b0, 1'b0, 1'b1);
    chk("first_cycle_done_cyc", done_cyc, 821);

    // go together with abort in IDLE stays idle
    reset_dut();
    for (int c = 1; c <= 10; c++) begin
      tick(c == 5, c == 5, 1'b0);
      if (c > 5) chk("go_abort_busy", bus.busy, 0);
    end

    // Randomized traffic against the reference model
    reset_dut();
    for (int c = 1; c <= 20000; c++) begin
      tick($urandom_range(49, 0) == 0, $urandom_range(2999, 0) == 0, $urandom_range(3, 0) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
